snax_csr_arbiter: RTL and testbench
===================================

SNAX_CSR_ARBITER -- requirements
Module: snax_csr_arbiter

Interface
REQ-001 Parameter NumReq, default 2: number of requester ports sharing one CSR port, legal range 2..8.
REQ-002 Parameter MaxOutstanding, default 4: depth of the response-routing FIFO, a power of two in the range 1..16.
REQ-003 Port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port req_data_i, input, NumReq x 32: per-requester CSR write data.
REQ-006 Port req_addr_i, input, NumReq x 32: per-requester CSR address.
REQ-007 Port req_write_i, input, NumReq x 1: per-requester write flag.
REQ-008 Port req_valid_i / req_ready_o, input / output, NumReq x 1 each: per-requester request handshake.
REQ-009 Port rsp_data_o, output, NumReq x 32: per-requester response data.
REQ-010 Port rsp_valid_o / rsp_ready_i, output / input, NumReq x 1 each: per-requester response handshake.
REQ-011 Port csr_req_data_o / csr_req_addr_o / csr_req_write_o, outputs, 32 / 32 / 1 bits: shared CSR request payload.
REQ-012 Port csr_req_valid_o / csr_req_ready_i, output / input, 1 bit each: shared CSR request handshake.
REQ-013 Port csr_rsp_data_i / csr_rsp_valid_i / csr_rsp_ready_o, input / input / output, 32 / 1 / 1 bits: shared CSR response channel.

Function
REQ-014 Arbitration shall be round-robin over requesters with req_valid_i high; the search starts at priority pointer rr_q.
REQ-015 A grant shall be held (locked) from the first cycle csr_req_valid_o is high until csr_req_ready_i is also high; other requesters and rr_q shall not change the grant meanwhile.
REQ-016 On a request handshake, rr_q shall become (granted index + 1) mod NumReq.
REQ-017 The csr_req payload outputs shall equal the granted requester's inputs combinationally; req_ready_o[g] shall equal csr_req_ready_i AND NOT fifo_full; all other req_ready_o bits shall be 0.
REQ-018 csr_req_valid_o shall be high only when some requester is valid and the FIFO is not full.
REQ-019 On each request handshake, the granted index shall be pushed into the response-routing FIFO; latency from req_valid_i to csr_req_valid_o is 0 cycles.
REQ-020 Responses shall be routed in request order to requester h = FIFO head: rsp_valid_o[h] = csr_rsp_valid_i AND NOT fifo_empty; rsp_data_o[h] = csr_rsp_data_i; all other rsp_valid_o bits shall be 0.
REQ-021 csr_rsp_ready_o shall equal rsp_ready_i[h] AND NOT fifo_empty; on a response handshake, the FIFO shall pop.
REQ-022 FIFO full: the grant is blocked even if a pop occurs in the same cycle; there shall be no combinational path from the response side to req_ready_o.
REQ-023 FIFO empty: csr_rsp_ready_o shall be 0, and a stray csr_rsp_valid_i shall be ignored and not routed.
REQ-024 A simultaneous push and pop with the FIFO neither full nor empty shall leave the occupancy unchanged; FIFO pointers shall wrap modulo MaxOutstanding.
REQ-025 A requester with req_valid_i high shall be granted within NumReq request handshakes (fairness).

Reset
REQ-026 While rst_i is high: rr_q = 0, FIFO empty, every valid and ready output = 0; the payload outputs are don't-care.
REQ-027 Reset asserted mid-transaction shall discard all outstanding routing entries; the environment is responsible for quiescing the CSR target.

Verification
REQ-028 Single request: req 0 valid with addr 0x10, write 1, data 0xA5; csr_req_ready_i = 1 -> same-cycle CSR request 0x10/1/0xA5; a response of 0x5A two cycles later appears only on rsp_data_o[0] with rsp_valid_o[0].
REQ-029 Round-robin: both requesters valid continuously, ready always high -> grants 0,1,0,1; responses return in matching order.
REQ-030 Grant lock: both requesters valid, csr_req_ready_i low for 3 cycles -> the payload stays on requester 0 with req_ready_o = 00; requester 1 is granted after the handshake.
REQ-031 Full FIFO: MaxOutstanding = 4, 4 requests accepted, no responses -> the 5th request sees csr_req_valid_o = 0; after one pop, the next cycle grants it.
REQ-032 Stray response: csr_rsp_valid_i high with the FIFO empty -> csr_rsp_ready_o = 0 and all rsp_valid_o = 0.
REQ-033 Async reset: rst_i pulses between clock edges with 2 entries outstanding -> outputs clear immediately; after release, the first request is granted to requester 0.

Source files
------------

// File: rtl/snax_csr_arbiter.sv
// snax_csr_arbiter
//   Shares one CSR request/response port between NumReq requesters.
//   Requests are arbitrated round-robin, and a grant stays locked until it is
//   accepted. The index of each accepted request is pushed into a small
//   routing FIFO. In-order CSR responses are then steered back to the
//   requester at the FIFO head.
//
// Ports
//   clk_i, rst_i                       clock, async active-high reset
//   req_{data,addr,write,valid}_i      per-requester request payload/valid
//   req_ready_o                        per-requester request ready
//   rsp_{data,valid}_o, rsp_ready_i    per-requester response channel
//   csr_req_{data,addr,write,valid}_o  shared CSR request
//   csr_req_ready_i
//   csr_rsp_{data,valid}_i             shared CSR response
//   csr_rsp_ready_o
module snax_csr_arbiter #(
  parameter int NumReq         = 2,
  parameter int MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumReq-1:0][31:0] req_data_i,
  input  logic [NumReq-1:0][31:0] req_addr_i,
  input  logic [NumReq-1:0]       req_write_i,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  output logic [NumReq-1:0][31:0] rsp_data_o,
  output logic [NumReq-1:0]       rsp_valid_o,
  input  logic [NumReq-1:0]       rsp_ready_i,
  output logic [31:0]             csr_req_data_o,
  output logic [31:0]             csr_req_addr_o,
  output logic                    csr_req_write_o,
  output logic                    csr_req_valid_o,
  input  logic                    csr_req_ready_i,
  input  logic [31:0]             csr_rsp_data_i,
  input  logic                    csr_rsp_valid_i,
  output logic                    csr_rsp_ready_o
);

  localparam int IdxW = $clog2(NumReq);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0] rr_q, lock_idx_q, rr_idx, grant, head;
  logic            lock_q, any_valid, grant_valid;
  logic            fifo_full, fifo_empty, push, pop;
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] fifo_mem [MaxOutstanding];

  // Round-robin search starting at rr_q. The loop walks offsets from the
  // farthest to the nearest, so the nearest valid requester is the last
  // one written and wins.
  always_comb begin
    rr_idx    = rr_q;
    any_valid = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      int s;
      s = int'(rr_q) + i;
      if (s >= NumReq) s = s - NumReq;
      if (req_valid_i[s]) begin
        rr_idx    = IdxW'(s);
        any_valid = 1'b1;
      end
    end
  end

  // While a request is pending without ready, keep presenting the same requester.
  assign grant       = lock_q ? lock_idx_q : rr_idx;
  assign grant_valid = lock_q ? req_valid_i[lock_idx_q] : any_valid;

  assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_mem[rptr_q];

  // Full blocks the grant regardless of a same-cycle pop. This keeps
  // req_ready_o free of any path from the response side.
  assign csr_req_valid_o = !rst_i && grant_valid && !fifo_full;
  assign csr_req_data_o  = req_data_i[grant];
  assign csr_req_addr_o  = req_addr_i[grant];
  assign csr_req_write_o = req_write_i[grant];

  always_comb begin
    req_ready_o        = '0;
    req_ready_o[grant] = !rst_i && csr_req_ready_i && !fifo_full;
  end

  // Responses go only to the FIFO head. A response that arrives while the
  // FIFO is empty is dropped.
  assign csr_rsp_ready_o = !rst_i && !fifo_empty && rsp_ready_i[head];

  always_comb begin
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    if (!fifo_empty) begin
      rsp_valid_o[head] = !rst_i && csr_rsp_valid_i;
      rsp_data_o[head]  = csr_rsp_data_i;
    end
  end

  assign push = csr_req_valid_o && csr_req_ready_i;
  assign pop  = csr_rsp_valid_i && csr_rsp_ready_o;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      lock_q     <= csr_req_valid_o && !csr_req_ready_i;
      lock_idx_q <= grant;
      if (push)
        rr_q <= (grant == IdxW'(NumReq - 1)) ? '0 : grant + 1'b1;
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // The routing storage needs no reset. Occupancy is tracked by cnt_q, and
  // clearing cnt_q discards every entry.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr_q] <= grant;
  end

endmodule

// File: tb/tb_snax_csr_arbiter.sv
module tb_snax_csr_arbiter;
  localparam int N  = 2;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0][31:0] req_data, req_addr, rsp_data;
  logic [N-1:0] req_write, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] csr_req_data, csr_req_addr, csr_rsp_data;
  logic csr_req_write, csr_req_valid, csr_req_ready, csr_rsp_valid, csr_rsp_ready;

  always #5 clk = ~clk;

  snax_csr_arbiter #(.NumReq(N), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_data_i(req_data), .req_addr_i(req_addr), .req_write_i(req_write),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .rsp_data_o(rsp_data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .csr_req_data_o(csr_req_data), .csr_req_addr_o(csr_req_addr),
    .csr_req_write_o(csr_req_write), .csr_req_valid_o(csr_req_valid),
    .csr_req_ready_i(csr_req_ready),
    .csr_rsp_data_i(csr_rsp_data), .csr_rsp_valid_i(csr_rsp_valid),
    .csr_rsp_ready_o(csr_rsp_ready)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic [1:0] rv;      // req_valid
    logic       crdy;    // csr_req_ready
    logic       rspv;    // csr_rsp_valid
    logic [1:0] rsprdy;  // rsp_ready
    logic       exp_cv;  // expected csr_req_valid
    int         exp_g;   // expected granted requester
    logic [1:0] exp_rr;  // expected req_ready
  } vec_t;

  function automatic vec_t mk(logic [1:0] rv, logic crdy, logic rspv, logic [1:0] rsprdy,
                              logic ecv, int eg, logic [1:0] err);
    vec_t v;
    v.rv = rv; v.crdy = crdy; v.rspv = rspv; v.rsprdy = rsprdy;
    v.exp_cv = ecv; v.exp_g = eg; v.exp_rr = err;
    return v;
  endfunction

  vec_t tbl[18];
  int   sb[$];  // expected response routing order

  task automatic idle();
    req_valid = '0; csr_req_ready = 0; csr_rsp_valid = 0; rsp_ready = '0; csr_rsp_data = '0;
    for (int i = 0; i < N; i++) begin
      req_data[i]  = 32'hD000_0000 | 32'(i);
      req_addr[i]  = 32'h100 + 32'(i);
      req_write[i] = i[0];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1;
    req_valid = 2'b11; csr_req_ready = 1; csr_rsp_valid = 1; rsp_ready = 2'b11;
    #1;
    chk("rst_csr_valid", csr_req_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_csr_rsp_ready", csr_rsp_ready, 0);
    @(negedge clk);
    idle();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    tbl[0]  = mk(2'b01, 1, 0, 2'b00, 1, 0, 2'b01);
    tbl[1]  = mk(2'b11, 1, 0, 2'b00, 1, 1, 2'b10);
    tbl[2]  = mk(2'b11, 1, 0, 2'b00, 1, 0, 2'b01);
    tbl[3]  = mk(2'b01, 0, 0, 2'b00, 1, 0, 2'b00);  // lock onto 0
    tbl[4]  = mk(2'b11, 0, 0, 2'b00, 1, 0, 2'b00);  // 1 arrives, rr favours 1, lock holds 0
    tbl[5]  = mk(2'b11, 1, 0, 2'b00, 1, 0, 2'b01);  // fills FIFO
    tbl[6]  = mk(2'b11, 1, 0, 2'b00, 0, 0, 2'b00);  // full
    tbl[7]  = mk(2'b11, 1, 1, 2'b11, 0, 0, 2'b00);  // full + pop: still blocked
    tbl[8]  = mk(2'b11, 1, 0, 2'b00, 1, 1, 2'b10);  // granted after pop
    tbl[9]  = mk(2'b00, 0, 1, 2'b00, 0, 0, 2'b00);  // head not ready
    tbl[10] = mk(2'b00, 0, 1, 2'b10, 0, 0, 2'b00);
    tbl[11] = mk(2'b00, 0, 1, 2'b11, 0, 0, 2'b00);
    tbl[12] = mk(2'b00, 0, 1, 2'b11, 0, 0, 2'b00);
    tbl[13] = mk(2'b00, 0, 1, 2'b11, 0, 0, 2'b00);
    tbl[14] = mk(2'b00, 0, 1, 2'b11, 0, 0, 2'b00);  // stray
    tbl[15] = mk(2'b10, 1, 0, 2'b00, 1, 1, 2'b10);
    tbl[16] = mk(2'b10, 1, 1, 2'b11, 1, 1, 2'b10);  // push and pop together
    tbl[17] = mk(2'b00, 0, 1, 2'b11, 0, 0, 2'b00);

    do_reset();

    for (int r = 0; r < 18; r++) begin
      int head;
      logic [1:0] exp_rv;
      logic exp_crsp;
      @(negedge clk);
      req_valid = tbl[r].rv; csr_req_ready = tbl[r].crdy;
      csr_rsp_valid = tbl[r].rspv; rsp_ready = tbl[r].rsprdy;
      csr_rsp_data = 32'h5A00_0000 + 32'(r);
      #1;
      head = (sb.size() > 0) ? sb[0] : 0;
      exp_rv = '0;
      if (sb.size() > 0 && tbl[r].rspv) exp_rv[head] = 1'b1;
      exp_crsp = (sb.size() > 0) && tbl[r].rsprdy[head];
      chk($sformatf("r%0d_csr_valid", r), csr_req_valid, tbl[r].exp_cv);
      chk($sformatf("r%0d_req_ready", r), req_ready, tbl[r].exp_rr);
      if (tbl[r].exp_cv) begin
        chk($sformatf("r%0d_addr", r), csr_req_addr, 32'h100 + 32'(tbl[r].exp_g));
        chk($sformatf("r%0d_data", r), csr_req_data, 32'hD000_0000 | 32'(tbl[r].exp_g));
        chk($sformatf("r%0d_write", r), csr_req_write, tbl[r].exp_g % 2);
      end
      chk($sformatf("r%0d_csr_rsp_ready", r), csr_rsp_ready, exp_crsp);
      chk($sformatf("r%0d_rsp_valid", r), rsp_valid, exp_rv);
      if (exp_rv != 0)
        chk($sformatf("r%0d_rsp_data", r), rsp_data[head], csr_rsp_data);
      if (tbl[r].rspv && exp_crsp) void'(sb.pop_front());
      if (tbl[r].exp_cv && tbl[r].crdy) sb.push_back(tbl[r].exp_g);
    end
    chk("sb_drained", sb.size(), 0);

    // Single request with a response two cycles later
    do_reset();
    req_valid = 2'b01; req_addr[0] = 32'h10; req_write[0] = 1; req_data[0] = 32'hA5;
    csr_req_ready = 1;
    #1;
    chk("single_valid", csr_req_valid, 1);
    chk("single_addr", csr_req_addr, 32'h10);
    chk("single_write", csr_req_write, 1);
    chk("single_data", csr_req_data, 32'hA5);
    @(negedge clk); req_valid = 0; csr_req_ready = 0;
    @(negedge clk);
    csr_rsp_valid = 1; csr_rsp_data = 32'h5A; rsp_ready = 2'b11;
    #1;
    chk("single_rsp_valid", rsp_valid, 2'b01);
    chk("single_rsp_data0", rsp_data[0], 32'h5A);
    chk("single_rsp_data1", rsp_data[1], 0);
    chk("single_csr_rsp_ready", csr_rsp_ready, 1);

    // Async reset with 2 entries outstanding
    do_reset();
    req_valid = 2'b01; csr_req_ready = 1;
    @(negedge clk);  // second request to 0, rr_q now 1
    @(negedge clk);
    req_valid = 2'b11; csr_req_ready = 0; csr_rsp_valid = 1; rsp_ready = 2'b11;
    #1;
    chk("pre_rst_grant", csr_req_addr, 32'h101);
    chk("pre_rst_rsp_valid", rsp_valid, 2'b01);
    rst = 1;
    #1;
    chk("async_csr_valid", csr_req_valid, 0);
    chk("async_req_ready", req_ready, 0);
    chk("async_rsp_valid", rsp_valid, 0);
    chk("async_csr_rsp_ready", csr_rsp_ready, 0);
    rst = 0;
    #1;
    chk("post_rst_valid", csr_req_valid, 1);
    chk("post_rst_grant", csr_req_addr, 32'h100);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_csr_rsp_ready", csr_rsp_ready, 0);
    @(negedge clk);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
